// File: rtl/compare_2bit.sv
// compare_2bit: registered eq/lt/gt flags plus min/max of two operands; result counters under COMPARE_2BIT_STATS_EN.
// Latency: 1 cycle from an in_valid edge to out_valid.
// Backpressure: none, so every in_valid beat is accepted.
module compare_2bit #(
  parameter int WIDTH  = 2,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic             out_valid,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt
);

  // Flipping the sign bit maps two's-complement order onto plain unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH-1)) : '0;

  logic [WIDTH-1:0] a_key, b_key;
  logic             a_lt_b, a_gt_b;

  assign a_key  = a ^ SIGN_MASK;
  assign b_key  = b ^ SIGN_MASK;
  assign a_lt_b = (a_key < b_key);
  assign a_gt_b = (a_key > b_key);

  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;

  always_comb begin
    eq_d  = eq_q;
    lt_d  = lt_q;
    gt_d  = gt_q;
    min_d = min_q;
    max_d = max_q;
    vld_d = in_valid;
    if (in_valid) begin
      eq_d  = ~a_lt_b & ~a_gt_b;
      lt_d  = a_lt_b;
      gt_d  = a_gt_b;
      min_d = a_gt_b ? b : a;
      max_d = a_lt_b ? b : a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      gt_q  <= 1'b0;
      vld_q <= 1'b0;
      min_q <= '0;
      max_q <= '0;
    end else begin
      eq_q  <= eq_d;
      lt_q  <= lt_d;
      gt_q  <= gt_d;
      vld_q <= vld_d;
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign eq        = eq_q;
  assign lt        = lt_q;
  assign gt        = gt_q;
  assign min_out   = min_q;
  assign max_out   = max_q;
  assign out_valid = vld_q;

`ifdef COMPARE_2BIT_STATS_EN
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    eq_cnt_d = eq_cnt_q;
    lt_cnt_d = lt_cnt_q;
    gt_cnt_d = gt_cnt_q;
    if (stats_clr) begin
      eq_cnt_d = '0;
      lt_cnt_d = '0;
      gt_cnt_d = '0;
    end else if (in_valid) begin
      if (!a_lt_b && !a_gt_b && (eq_cnt_q != '1)) eq_cnt_d = eq_cnt_q + CNT_W'(1);
      if (a_lt_b && (lt_cnt_q != '1))             lt_cnt_d = lt_cnt_q + CNT_W'(1);
      if (a_gt_b && (gt_cnt_q != '1))             gt_cnt_d = gt_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_cnt_q <= '0;
      lt_cnt_q <= '0;
      gt_cnt_q <= '0;
    end else begin
      eq_cnt_q <= eq_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      gt_cnt_q <= gt_cnt_d;
    end
  end

  assign eq_cnt = eq_cnt_q;
  assign lt_cnt = lt_cnt_q;
  assign gt_cnt = gt_cnt_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign eq_cnt = '0;
  assign lt_cnt = '0;
  assign gt_cnt = '0;
`endif

endmodule

// File: tb/tb_compare_2bit.sv
// Self-checking bench: unsigned (CNT_W=8) and signed (CNT_W=2) comparators share the stimulus.
// Expected values come from an integer-ordering model plus hand-computed literals.
module tb_compare_2bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       stats_clr;
  logic [1:0] a, b;

  logic       u_eq, u_lt, u_gt, u_vld;
  logic [1:0] u_min, u_max;
  logic [7:0] u_ec, u_lc, u_gc;

  logic       s_eq, s_lt, s_gt, s_vld;
  logic [1:0] s_min, s_max;
  logic [1:0] s_ec, s_lc, s_gc;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  compare_2bit #(.WIDTH(2), .SIGNED(0), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .eq(u_eq), .lt(u_lt), .gt(u_gt), .min_out(u_min), .max_out(u_max),
    .out_valid(u_vld), .stats_clr(stats_clr),
    .eq_cnt(u_ec), .lt_cnt(u_lc), .gt_cnt(u_gc)
  );

  compare_2bit #(.WIDTH(2), .SIGNED(1), .CNT_W(2)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .eq(s_eq), .lt(s_lt), .gt(s_gt), .min_out(s_min), .max_out(s_max),
    .out_valid(s_vld), .stats_clr(stats_clr),
    .eq_cnt(s_ec), .lt_cnt(s_lc), .gt_cnt(s_gc)
  );

  // Counter values only show up on the ports when the stats feature is built in.
  function automatic int ecnt(input int v);
`ifdef COMPARE_2BIT_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Numeric value of a 2-bit code: index 0 is unsigned, index 1 two's complement.
  function automatic int key(input int x, input int k);
    if (k == 1 && x >= 2) return x - 4;
    return x;
  endfunction

  function automatic int cap(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  int m_eq[2], m_lt[2], m_gt[2], m_vld[2], m_min[2], m_max[2];
  int m_ec[2], m_lc[2], m_gc[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_eq[k] = 0; m_lt[k] = 0; m_gt[k] = 0; m_vld[k] = 0;
        m_min[k] = 0; m_max[k] = 0; m_ec[k] = 0; m_lc[k] = 0; m_gc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int ka, kb;
        ka = key(int'(a), k);
        kb = key(int'(b), k);
        m_vld[k] = int'(in_valid);
        if (in_valid) begin
          m_eq[k]  = (ka == kb) ? 1 : 0;
          m_lt[k]  = (ka <  kb) ? 1 : 0;
          m_gt[k]  = (ka >  kb) ? 1 : 0;
          m_min[k] = (ka <= kb) ? int'(a) : int'(b);
          m_max[k] = (ka >= kb) ? int'(a) : int'(b);
        end
        if (stats_clr) begin
          m_ec[k] = 0; m_lc[k] = 0; m_gc[k] = 0;
        end else if (in_valid) begin
          if (ka == kb && m_ec[k] < cap(k)) m_ec[k]++;
          if (ka <  kb && m_lc[k] < cap(k)) m_lc[k]++;
          if (ka >  kb && m_gc[k] < cap(k)) m_gc[k]++;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u.eq", int'(u_eq), m_eq[0]);     chk("s.eq", int'(s_eq), m_eq[1]);
      chk("u.lt", int'(u_lt), m_lt[0]);     chk("s.lt", int'(s_lt), m_lt[1]);
      chk("u.gt", int'(u_gt), m_gt[0]);     chk("s.gt", int'(s_gt), m_gt[1]);
      chk("u.vld", int'(u_vld), m_vld[0]);  chk("s.vld", int'(s_vld), m_vld[1]);
      chk("u.min", int'(u_min), m_min[0]);  chk("s.min", int'(s_min), m_min[1]);
      chk("u.max", int'(u_max), m_max[0]);  chk("s.max", int'(s_max), m_max[1]);
      chk("u.eq_cnt", int'(u_ec), ecnt(m_ec[0]));  chk("s.eq_cnt", int'(s_ec), ecnt(m_ec[1]));
      chk("u.lt_cnt", int'(u_lc), ecnt(m_lc[0]));  chk("s.lt_cnt", int'(s_lc), ecnt(m_lc[1]));
      chk("u.gt_cnt", int'(u_gc), ecnt(m_gc[0]));  chk("s.gt_cnt", int'(s_gc), ecnt(m_gc[1]));
    end
  end

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input logic v, input logic [1:0] aa, input logic [1:0] bb, input logic clr);
    in_valid  = v;
    a         = aa;
    b         = bb;
    stats_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".u_flags"}, int'({u_eq, u_lt, u_gt, u_vld}), 0);
    chk({tag, ".u_minmax"}, int'({u_min, u_max}), 0);
    chk({tag, ".s_flags"}, int'({s_eq, s_lt, s_gt, s_vld}), 0);
    chk({tag, ".s_minmax"}, int'({s_min, s_max}), 0);
    chk({tag, ".u_cnts"}, int'(u_ec) + int'(u_lc) + int'(u_gc), 0);
    chk({tag, ".s_cnts"}, int'(s_ec) + int'(s_lc) + int'(s_gc), 0);
  endtask

  task automatic random_burst(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
           1'($urandom_range(0, 19) == 0));
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; stats_clr = 1'b0; a = 2'b00; b = 2'b00;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'(i >> 2), 2'(i & 3), 1'b0);
      if (i == 6) begin
        chk("sweep01_10.u_lt", int'(u_lt), 1);
        chk("sweep01_10.u_min", int'(u_min), 1);
        chk("sweep01_10.u_max", int'(u_max), 2);
      end
      if (i == 9) begin
        chk("sweep10_01.s_lt", int'(s_lt), 1);
        chk("sweep10_01.s_min", int'(s_min), 2);
      end
      chk("sweep.u_vld", int'(u_vld), 1);
    end
    chk("sweep.u_eq_cnt", int'(u_ec), ecnt(4));
    chk("sweep.u_lt_cnt", int'(u_lc), ecnt(6));
    chk("sweep.u_gt_cnt", int'(u_gc), ecnt(6));
    chk("sweep.s_eq_cnt_sat", int'(s_ec), ecnt(3));
    chk("sweep.s_lt_cnt_sat", int'(s_lc), ecnt(3));

    step(1'b1, 2'b11, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b11, 1'b0);
    chk("hold.u_gt", int'(u_gt), 1);
    chk("hold.u_max", int'(u_max), 3);
    chk("hold.u_vld", int'(u_vld), 0);
    chk("hold.s_lt", int'(s_lt), 1);

    step(1'b1, 2'b10, 2'b01, 1'b0);
    chk("signed10_01.lt", int'(s_lt), 1);
    chk("signed10_01.min", int'(s_min), 2);
    step(1'b1, 2'b11, 2'b10, 1'b0);
    chk("signed11_10.gt", int'(s_gt), 1);
    step(1'b1, 2'b00, 2'b11, 1'b0);
    chk("signed00_11.gt", int'(s_gt), 1);
    chk("signed00_11.max", int'(s_max), 0);

    step(1'b1, 2'b01, 2'b01, 1'b1);
    chk("clr.u_cnts", int'(u_ec) + int'(u_lc) + int'(u_gc), 0);
    chk("clr.s_cnts", int'(s_ec) + int'(s_lc) + int'(s_gc), 0);
    chk("clr.u_eq", int'(u_eq), 1);

    repeat (10) step(1'b1, 2'b10, 2'b01, 1'b0);
    chk("sat.s_lt_cnt", int'(s_lc), ecnt(3));
    chk("sat.u_gt_cnt", int'(u_gc), ecnt(10));

    random_burst(300);

    step(1'b1, 2'b10, 2'b11, 1'b0);
    in_valid = 1'b1; a = 2'b01; b = 2'b00;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 2'b01, 2'b11, 1'b0);
    chk("postreset.u_lt", int'(u_lt), 1);
    chk("postreset.u_min", int'(u_min), 1);
    chk("postreset.u_max", int'(u_max), 3);
    chk("postreset.u_lt_cnt", int'(u_lc), ecnt(1));

    random_burst(200);

    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
